// File: rtl/atm_pkg.sv
// Shared ATM definitions: state codes, datapath status codes and menu options.
// Used by atm_session_fsm and by the transaction datapath.
package atm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE                      = 4'd0,
        ST_ACC_NUM                   = 4'd1,
        ST_PIN_INPUT                 = 4'd2,
        ST_MENU                      = 4'd3,
        ST_SHOW_BALANCES             = 4'd4,
        ST_CONVERT_CURRENCY          = 4'd5,
        ST_SELECT_CURRENCY_CONVERT_1 = 4'd6,
        ST_SELECT_CURRENCY_CONVERT_2 = 4'd7,
        ST_WITHDRAW                  = 4'd8,
        ST_SELECT_AMOUNT_WITHDRAW    = 4'd9,
        ST_TRANSFER                  = 4'd10,
        ST_SELECT_CURRENCY_TRANSFER  = 4'd11,
        ST_SELECT_AMOUNT_TRANSFER    = 4'd12,
        ST_ERROR                     = 4'd13,
        ST_SUCCESS                   = 4'd14
    } atm_state_e;

    localparam logic [3:0] SC_ACC_FOUND     = 4'd1;
    localparam logic [3:0] SC_ACC_NOT_FOUND = 4'd2;
    localparam logic [3:0] SC_PIN_CORRECT   = 4'd3;
    localparam logic [3:0] SC_PIN_INCORRECT = 4'd4;
    localparam logic [3:0] SC_AMT_VALID     = 4'd5;
    localparam logic [3:0] SC_AMT_INVALID   = 4'd6;
    localparam logic [3:0] SC_EXIT          = 4'd7;

    localparam logic [1:0] MENU_SHOW_BALANCES = 2'd0;
    localparam logic [1:0] MENU_CONVERT       = 2'd1;
    localparam logic [1:0] MENU_WITHDRAW      = 2'd2;
    localparam logic [1:0] MENU_TRANSFER      = 2'd3;

    function automatic logic is_checked_state(input atm_state_e s);
        return (s == ST_ACC_NUM) || (s == ST_PIN_INPUT) ||
               (s == ST_SELECT_AMOUNT_WITHDRAW) || (s == ST_SELECT_AMOUNT_TRANSFER);
    endfunction

    function automatic logic is_msg_state(input atm_state_e s);
        return (s == ST_ERROR) || (s == ST_SUCCESS);
    endfunction

    // States in which the inactivity timer is allowed to run
    function automatic logic is_timed_state(input atm_state_e s);
        return (s != ST_IDLE) && !is_msg_state(s);
    endfunction

endpackage

// File: rtl/atm_hold_timer.sv
// Loadable down-counter; done is high in the last counted cycle so the
// consumer acts on the edge where the count expires.
module atm_hold_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count_r;

    // Count register: load has priority, otherwise count down to zero while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = en && (count_r == WIDTH'(1));

endmodule

// File: rtl/atm_session_fsm.sv
// ATM session controller: state sequencing, PIN retries, status checks and
// message hold. Optional inactivity timeout enabled by `define ATM_TIMEOUT_EN.
module atm_session_fsm
    import atm_pkg::*;
#(
    parameter int MAX_PIN_TRIES   = 3,
    parameter int CHECK_LAT       = 2,
    parameter int MSG_HOLD_CYCLES = 8,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enter,
    input  logic        cancel,
    input  logic [1:0]  menuOption,
    input  logic [3:0]  status_code,
    output logic [3:0]  current_state,
    output logic [15:0] state_onehot,
    output logic        authenticated,
    output logic [1:0]  tries_left,
    output logic        busy,
    output logic        timeout_pulse
);

    localparam int HOLD_MAX = (CHECK_LAT > MSG_HOLD_CYCLES) ? CHECK_LAT : MSG_HOLD_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [1:0] TRIES_MAX = 2'(MAX_PIN_TRIES);

    atm_state_e  state_r, state_n;
    logic [15:0] onehot_r;
    logic        auth_r, auth_n;
    logic [1:0]  tries_r, tries_n;
    logic        busy_r, busy_n;
    logic        tmo_pulse_r;
    logic        start_check_s;
    logic        hold_load_s;
    logic [HOLD_W-1:0] hold_val_s;
    logic        hold_done_s;
    logic        tmo_fire_s;

    // One timer serves both the check latency and the message hold; they never overlap
    atm_hold_timer #(.WIDTH(HOLD_W)) u_hold_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hold_load_s),
        .load_val (hold_val_s),
        .en       (1'b1),
        .done     (hold_done_s)
    );

`ifdef ATM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic tmo_evt_s;
    logic tmo_load_s;
    logic tmo_done_s;

    assign tmo_evt_s  = !busy_r && !is_msg_state(state_r) &&
                        (enter || (cancel && (state_r != ST_IDLE)));
    assign tmo_load_s = !is_timed_state(state_r) || tmo_evt_s;

    atm_hold_timer #(.WIDTH(TMO_W)) u_tmo_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmo_load_s),
        .load_val (TMO_W'(TIMEOUT_CYCLES)),
        .en       (!busy_r),
        .done     (tmo_done_s)
    );

    assign tmo_fire_s = tmo_done_s && is_timed_state(state_r);
`else
    // No inactivity counter in this build
    assign tmo_fire_s = 1'b0 && (TIMEOUT_CYCLES < 0);
`endif

    // Next-state, session bookkeeping and timer load decisions
    always_comb begin
        state_n       = state_r;
        auth_n        = auth_r;
        tries_n       = tries_r;
        busy_n        = busy_r;
        start_check_s = 1'b0;
        hold_load_s   = 1'b0;
        hold_val_s    = {HOLD_W{1'b0}};

        if (tmo_fire_s) begin
            state_n = ST_IDLE;
            auth_n  = 1'b0;
            tries_n = TRIES_MAX;
            busy_n  = 1'b0;
        end else if (busy_r) begin
            if (hold_done_s) begin
                busy_n = 1'b0;
                case (state_r)
                    ST_ACC_NUM: begin
                        case (status_code)
                            SC_ACC_FOUND:     state_n = ST_PIN_INPUT;
                            SC_ACC_NOT_FOUND: state_n = ST_ERROR;
                            SC_EXIT: begin
                                state_n = ST_IDLE;
                                auth_n  = 1'b0;
                                tries_n = TRIES_MAX;
                            end
                            default:          state_n = ST_ERROR;
                        endcase
                    end
                    ST_PIN_INPUT: begin
                        case (status_code)
                            SC_PIN_CORRECT: begin
                                state_n = ST_MENU;
                                auth_n  = 1'b1;
                                tries_n = TRIES_MAX;
                            end
                            SC_PIN_INCORRECT: begin
                                if (tries_r <= 2'd1) begin
                                    tries_n = 2'd0;
                                    state_n = ST_ERROR;
                                end else begin
                                    tries_n = tries_r - 2'd1;
                                    state_n = ST_PIN_INPUT;
                                end
                            end
                            SC_EXIT: begin
                                state_n = ST_IDLE;
                                auth_n  = 1'b0;
                                tries_n = TRIES_MAX;
                            end
                            default:        state_n = ST_ERROR;
                        endcase
                    end
                    ST_SELECT_AMOUNT_WITHDRAW, ST_SELECT_AMOUNT_TRANSFER: begin
                        case (status_code)
                            SC_AMT_VALID:   state_n = ST_SUCCESS;
                            SC_AMT_INVALID: state_n = ST_ERROR;
                            SC_EXIT: begin
                                state_n = ST_IDLE;
                                auth_n  = 1'b0;
                                tries_n = TRIES_MAX;
                            end
                            default:        state_n = ST_ERROR;
                        endcase
                    end
                    default: begin
                        state_n = ST_IDLE;
                        auth_n  = 1'b0;
                        tries_n = TRIES_MAX;
                    end
                endcase
            end else begin
                busy_n = 1'b1;
            end
        end else if (is_msg_state(state_r)) begin
            if (hold_done_s) begin
                if (auth_r) begin
                    state_n = ST_MENU;
                end else begin
                    state_n = ST_IDLE;
                    tries_n = TRIES_MAX;
                end
            end else begin
                state_n = state_r;
            end
        end else if (cancel && (state_r != ST_IDLE)) begin
            if ((state_r == ST_MENU) || !auth_r) begin
                state_n = ST_IDLE;
                auth_n  = 1'b0;
                tries_n = TRIES_MAX;
            end else begin
                state_n = ST_MENU;
            end
        end else if (enter) begin
            if (is_checked_state(state_r)) begin
                busy_n        = 1'b1;
                start_check_s = 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE:                      state_n = ST_ACC_NUM;
                    ST_MENU: begin
                        case (menuOption)
                            MENU_SHOW_BALANCES: state_n = ST_SHOW_BALANCES;
                            MENU_CONVERT:       state_n = ST_CONVERT_CURRENCY;
                            MENU_WITHDRAW:      state_n = ST_WITHDRAW;
                            MENU_TRANSFER:      state_n = ST_TRANSFER;
                            default:            state_n = ST_MENU;
                        endcase
                    end
                    ST_SHOW_BALANCES:             state_n = ST_MENU;
                    ST_CONVERT_CURRENCY:          state_n = ST_SELECT_CURRENCY_CONVERT_1;
                    ST_SELECT_CURRENCY_CONVERT_1: state_n = ST_SELECT_CURRENCY_CONVERT_2;
                    ST_SELECT_CURRENCY_CONVERT_2: state_n = ST_SUCCESS;
                    ST_WITHDRAW:                  state_n = ST_SELECT_AMOUNT_WITHDRAW;
                    ST_TRANSFER:                  state_n = ST_SELECT_CURRENCY_TRANSFER;
                    ST_SELECT_CURRENCY_TRANSFER:  state_n = ST_SELECT_AMOUNT_TRANSFER;
                    default:                      state_n = state_r;
                endcase
            end
        end else begin
            state_n = state_r;
        end

        if (start_check_s) begin
            hold_load_s = 1'b1;
            hold_val_s  = HOLD_W'(CHECK_LAT);
        end else if (is_msg_state(state_n) && !is_msg_state(state_r)) begin
            hold_load_s = 1'b1;
            hold_val_s  = HOLD_W'(MSG_HOLD_CYCLES);
        end else begin
            hold_load_s = 1'b0;
            hold_val_s  = {HOLD_W{1'b0}};
        end
    end

    // State and output registers; the one-hot copy is registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            onehot_r    <= 16'h0001;
            auth_r      <= 1'b0;
            tries_r     <= TRIES_MAX;
            busy_r      <= 1'b0;
            tmo_pulse_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            onehot_r    <= 16'd1 << state_n;
            auth_r      <= auth_n;
            tries_r     <= tries_n;
            busy_r      <= busy_n;
            tmo_pulse_r <= tmo_fire_s;
        end
    end

    assign current_state = state_r;
    assign state_onehot  = onehot_r;
    assign authenticated = auth_r;
    assign tries_left    = tries_r;
    assign busy          = busy_r;
    assign timeout_pulse = tmo_pulse_r;

endmodule

// File: doc/atm_session_fsm.md
# atm_session_fsm

Session controller that sits directly upstream of the ATM transaction datapath. It turns front-panel `enter`/`cancel` pulses and the datapath's `status_code` into the 4-bit `current_state` that drives the datapath. It also produces the one-hot debug LED vector. It owns PIN-retry counting, result-message hold timing and the optional inactivity timeout.

## Interface
- `MAX_PIN_TRIES`, default 3: PIN attempts allowed per session (1..3).
- `CHECK_LAT`, default 2: cycles between `enter` and sampling of `status_code`.
- `MSG_HOLD_CYCLES`, default 8: cycles spent in ERROR/SUCCESS.
- `TIMEOUT_CYCLES`, default 1000: inactivity limit (only with `ATM_TIMEOUT_EN`).
- `clk`  in  1  system clock; everything is synchronous to its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `enter`  in  1  single-cycle confirm pulse.
- `cancel`  in  1  single-cycle back/cancel pulse.
- `menuOption`  in  2  menu selection, sampled on `enter` in MENU.
- `status_code`  in  4  result code from the datapath.
- `current_state`  out  4  encoded state, fed to the datapath.
- `state_onehot`  out  16  `1 << current_state`, for the debug LEDs.
- `authenticated`  out  1  session holds a verified PIN.
- `tries_left`  out  2  remaining PIN attempts.
- `busy`  out  1  a status check is in progress.
- `timeout_pulse`  out  1  one-cycle pulse when the inactivity timeout fires.

## Operation
**State codes:**
- IDLE 0, ACC_NUM 1, PIN_INPUT 2, MENU 3, SHOW_BALANCES 4, CONVERT_CURRENCY 5.
- SELECT_CURRENCY_CONVERT_1 6, SELECT_CURRENCY_CONVERT_2 7, WITHDRAW 8, SELECT_AMOUNT_WITHDRAW 9.
- TRANSFER 10, SELECT_CURRENCY_TRANSFER 11, SELECT_AMOUNT_TRANSFER 12, ERROR 13, SUCCESS 14.

**Status codes:** ACC_FOUND 1, ACC_NOT_FOUND 2, PIN_CORRECT 3, PIN_INCORRECT 4, AMT_VALID 5, AMT_INVALID 6, EXIT 7.

**Checked states:** ACC_NUM, PIN_INPUT, SELECT_AMOUNT_WITHDRAW, SELECT_AMOUNT_TRANSFER.
- `enter` in a checked state sets `busy` and holds the state.
- `status_code` is sampled `CHECK_LAT` cycles later; `busy` clears in that cycle.
- `enter` and `cancel` are ignored while `busy`.

**Transitions:**
- IDLE --enter--> ACC_NUM.
- ACC_NUM check: ACC_FOUND goes to PIN_INPUT; ACC_NOT_FOUND goes to ERROR.
- PIN_INPUT check, PIN_CORRECT: go to MENU; `authenticated`=1; `tries_left`=MAX.
- PIN_INPUT check, PIN_INCORRECT: decrement `tries_left`. If it reaches 0, go to ERROR (lockout); otherwise stay in PIN_INPUT.
- MENU --enter--> menuOption 0 SHOW_BALANCES, 1 CONVERT_CURRENCY, 2 WITHDRAW, 3 TRANSFER.
- SHOW_BALANCES --enter--> MENU.
- CONVERT_CURRENCY → SELECT_CURRENCY_CONVERT_1 → SELECT_CURRENCY_CONVERT_2 → SUCCESS, advancing on `enter`.
- WITHDRAW --enter--> SELECT_AMOUNT_WITHDRAW.
- TRANSFER --enter--> SELECT_CURRENCY_TRANSFER --enter--> SELECT_AMOUNT_TRANSFER.
- Amount checks: AMT_VALID goes to SUCCESS; AMT_INVALID goes to ERROR.
- In any check, EXIT goes to IDLE and clears the session; any code not valid for that state goes to ERROR.
- ERROR/SUCCESS: stay `MSG_HOLD_CYCLES` cycles, ignoring inputs. Then go to MENU if `authenticated`, else IDLE. The IDLE path resets `tries_left`.

**cancel** (outside IDLE/ERROR/SUCCESS, not busy):
- From MENU, or any state while unauthenticated: go to IDLE and clear the session.
- Otherwise: go to MENU.

**Simultaneous events:**
- `enter` and `cancel` in the same cycle: `cancel` wins.
- Timeout in the same cycle as a check sample: timeout wins.

**Clearing a session:** `authenticated`=0 and `tries_left`=MAX_PIN_TRIES.

## Timing
- **Reset values:** `current_state`=0, `state_onehot`=16'h0001, `authenticated`=0, `tries_left`=MAX_PIN_TRIES, `busy`=0, `timeout_pulse`=0. Reset asserted mid-check aborts the check.
- All outputs are registered. The state changes in the cycle after the accepted `enter`, or in the cycle after the sample cycle for checks.
- `status_code` is sampled at the rising edge `CHECK_LAT` cycles after the edge that accepted `enter`.
- ERROR/SUCCESS are visible for exactly `MSG_HOLD_CYCLES` cycles.

## Configuration
**`ATM_TIMEOUT_EN` defined:**
- An inactivity counter runs in every state except IDLE and ERROR/SUCCESS.
- It reloads on any accepted `enter`/`cancel` and is frozen while `busy`.
- When it reaches `TIMEOUT_CYCLES`: go to IDLE, clear the session, and pulse `timeout_pulse` for 1 cycle.

**`ATM_TIMEOUT_EN` undefined:** no counter is present and `timeout_pulse` is tied to 0.

## Structure
- Package `atm_pkg` holds the state-code enum, the status-code constants and the menu option constants. These are shared with the datapath.
- One sub-module, `atm_hold_timer`: a loadable down-counter with a done pulse. Instantiate it once for the CHECK_LAT/MSG_HOLD wait and once for the timeout (timeout instance only under `ATM_TIMEOUT_EN`).

## Test plan
- Reset, then `enter`; drive ACC_FOUND and `enter`, then PIN_CORRECT → states 0→1→2→3, `authenticated`=1, `tries_left`=3.
- Three PIN checks returning PIN_INCORRECT → `tries_left` 2, 1, then ERROR(13) held 8 cycles → IDLE, `tries_left`=3.
- MENU with `menuOption`=2, enter, enter, AMT_INVALID → ERROR held 8 cycles → MENU(3).
- MENU with `menuOption`=3: enter ×3 then AMT_VALID → 10, 11, 12, then SUCCESS(14) → MENU.
- `enter` and `cancel` asserted together in SHOW_BALANCES → MENU; `cancel` in MENU → IDLE with `authenticated`=0.
- With `ATM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20, idle in MENU → IDLE after 20 cycles and one `timeout_pulse`. Without the macro, the bench stays in MENU and `timeout_pulse` stays 0.
